// File: rtl/sccb_master.sv
// SCCB master for OV2640 register writes/reads over open-drain SCL/SDA.
// Define SCCB_ACK_CHECK_EN to abort on a slave NACK and report rsp_nack.
module sccb_master #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [6:0]  DEV_ADDR = 7'h30
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_nack,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in,
  output logic [3:0] dbg_state
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_TX    = 4'd2;
  localparam logic [3:0] S_ACK   = 4'd3;
  localparam logic [3:0] S_RX    = 4'd4;
  localparam logic [3:0] S_MACK  = 4'd5;
  localparam logic [3:0] S_STOP  = 4'd6;
  localparam logic [3:0] S_GAP   = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam logic [9:0] DIV_M1 = 10'(CLK_DIV - 1);

  logic [3:0] state;
  logic [9:0] cnt;
  logic [1:0] q;
  logic [2:0] bit_cnt;
  logic [1:0] byte_no;
  logic       restarted;
  logic       rd_lat;
  logic [7:0] addr_lat;
  logic [7:0] wdata_lat;
  logic [7:0] sh;
  logic [7:0] rx;
  logic       nack_seen;
  logic       accept;
  logic       tick;
  logic       seg_end;
  logic       q_mid;

  assign accept  = cmd_valid && cmd_ready;
  assign tick    = (state != S_IDLE) && (state != S_DONE)
                && (cnt == DIV_M1);
  assign seg_end = tick && (q == 2'd3);
  assign q_mid   = tick && (q == 2'd2);

  assign rsp_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Bit quarters: q0 SCL low/SDA set, q1 release, q2 high/sample, q3 low
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    unique case (state)
      S_START: begin
        scl_oe = (q == 2'd3);
        sda_oe = (q != 2'd0);
      end
      S_TX: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
        sda_oe = !sh[7];
      end
      S_ACK, S_RX, S_MACK: begin
        scl_oe = (q == 2'd0) || (q == 2'd3);
      end
      S_STOP: begin
        scl_oe = (q == 2'd0);
        sda_oe = (q != 2'd3);
      end
      default: begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      q         <= '0;
      bit_cnt   <= '0;
      byte_no   <= '0;
      restarted <= 1'b0;
      rd_lat    <= 1'b0;
      addr_lat  <= '0;
      wdata_lat <= '0;
      sh        <= '0;
      rx        <= '0;
      nack_seen <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_rdata <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      if ((state == S_IDLE) || (state == S_DONE) || tick)
        cnt <= '0;
      else
        cnt <= cnt + 10'd1;
      if (tick)
        q <= q + 2'd1;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            state     <= S_START;
            cmd_ready <= 1'b0;
            rd_lat    <= cmd_rd;
            addr_lat  <= cmd_addr;
            wdata_lat <= cmd_wdata;
            restarted <= 1'b0;
            nack_seen <= 1'b0;
            q         <= '0;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        S_START: begin
          if (seg_end) begin
            state   <= S_TX;
            bit_cnt <= '0;
            byte_no <= '0;
            sh      <= {DEV_ADDR, restarted};
          end
        end
        S_TX: begin
          if (seg_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            sh      <= {sh[6:0], 1'b0};
            if (bit_cnt == 3'd7)
              state <= S_ACK;
          end
        end
        S_ACK: begin
`ifdef SCCB_ACK_CHECK_EN
          if (q_mid)
            nack_seen <= sda_in;
`endif
          if (seg_end) begin
            byte_no <= byte_no + 2'd1;
            if (nack_seen) begin
              state <= S_STOP;
            end else if (restarted) begin
              state <= S_RX;
            end else if (byte_no == 2'd0) begin
              state <= S_TX;
              sh    <= addr_lat;
            end else if ((byte_no == 2'd1) && !rd_lat) begin
              state <= S_TX;
              sh    <= wdata_lat;
            end else begin
              state <= S_STOP;
            end
          end
        end
        S_RX: begin
          if (q_mid)
            rx <= {rx[6:0], sda_in};
          if (seg_end) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              state <= S_MACK;
          end
        end
        S_MACK: begin
          if (seg_end)
            state <= S_STOP;
        end
        S_STOP: begin
          if (seg_end) begin
            if (rd_lat && !restarted && !nack_seen) begin
              state <= S_GAP;
            end else begin
              state    <= S_DONE;
              rsp_nack <= nack_seen;
              if (rd_lat && !nack_seen)
                rsp_rdata <= rx;
            end
          end
        end
        S_GAP: begin
          if (seg_end) begin
            state     <= S_START;
            restarted <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Bench for sccb_master: open-drain slave model, bus decoder and
// transaction-level reference for events, latency and response.
module tb_sccb_master;

  localparam int CLK_DIV = 4;
  localparam int EV_S = 1000;
  localparam int EV_P = 2000;
  localparam logic [7:0] DEV_W = 8'h60;
  localparam logic [7:0] DEV_R = 8'h61;
`ifdef SCCB_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rd;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;
  logic       busy;
  logic       scl_oe;
  logic       sda_oe;
  logic       sda_in;
  logic [3:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic       slv_pull = 1'b0;
  bit         slv_silent = 1'b0;
  logic [7:0] slv_data = 8'h00;
  bit         mon_en = 1'b0;
  logic       scl_p = 1'b1;
  logic       sda_p = 1'b1;
  int         bitn = 0;
  int         byte_no = 0;
  bit         rd_mode = 1'b0;
  logic [7:0] shreg = 8'h00;
  int         hi_cnt = 0;
  int         hi_min = 1000000;
  int         mon_q[$];
  logic [7:0] ref_rdata = 8'h00;

  always #5 clk = ~clk;

  assign sda_in = !(sda_oe || slv_pull);

  sccb_master #(
    .CLK_DIV  (CLK_DIV),
    .DEV_ADDR (7'h30)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_nack  (rsp_nack),
    .busy      (busy),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .sda_in    (sda_in),
    .dbg_state (dbg_state)
  );

  function automatic int ev_b(input logic [7:0] b, input logic a);
    return (int'(b) << 1) | int'(a);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus decoder plus slave: ACKs written bytes, drives read data
  always @(negedge clk) begin
    logic bscl;
    logic bsda;
    bscl = !scl_oe;
    bsda = !(sda_oe || slv_pull);
    if (!mon_en) begin
      bitn     <= 0;
      byte_no  <= 0;
      rd_mode  <= 1'b0;
      slv_pull <= 1'b0;
      hi_cnt   <= 0;
    end else begin
      if (bscl && scl_p && (bsda != sda_p)) begin
        if (!bsda) begin
          mon_q.push_back(EV_S);
          bitn    <= 0;
          byte_no <= 0;
          rd_mode <= 1'b0;
        end else begin
          mon_q.push_back(EV_P);
          slv_pull <= 1'b0;
        end
      end else if (bscl && !scl_p) begin
        shreg <= {shreg[6:0], bsda};
        if (bitn == 8) begin
          mon_q.push_back(ev_b(shreg, bsda));
          bitn    <= 0;
          byte_no <= byte_no + 1;
          if (byte_no == 0)
            rd_mode <= shreg[0];
        end else begin
          bitn <= bitn + 1;
        end
      end else if (!bscl && scl_p) begin
        if (hi_cnt < hi_min)
          hi_min <= hi_cnt;
        if (slv_silent)
          slv_pull <= 1'b0;
        else if ((byte_no == 1) && rd_mode)
          slv_pull <= (bitn < 8) ? !slv_data[7 - bitn] : 1'b0;
        else
          slv_pull <= (bitn == 8);
      end
      hi_cnt <= bscl ? hi_cnt + 1 : 0;
    end
    scl_p <= bscl;
    sda_p <= bsda;
  end

  task automatic xact(input bit rd, input logic [7:0] addr,
                      input logic [7:0] wd, input bit silent,
                      input logic [7:0] sd, input bit keep,
                      output int acc_wait);
    int exp_q[$];
    int base, n, j, nb, ns, np, ticks, bad;
    bit ack, nk;
    logic [7:0] rxb;
    ack = silent;
    nk  = silent && ACK_CHK;
    rxb = silent ? 8'hFF : sd;
    exp_q.push_back(EV_S);
    exp_q.push_back(ev_b(DEV_W, ack));
    if (nk) begin
      exp_q.push_back(EV_P);
    end else if (!rd) begin
      exp_q.push_back(ev_b(addr, ack));
      exp_q.push_back(ev_b(wd, ack));
      exp_q.push_back(EV_P);
    end else begin
      exp_q.push_back(ev_b(addr, ack));
      exp_q.push_back(EV_P);
      exp_q.push_back(EV_S);
      exp_q.push_back(ev_b(DEV_R, ack));
      exp_q.push_back(ev_b(rxb, 1'b1));
      exp_q.push_back(EV_P);
    end
    nb = 0; ns = 0; np = 0;
    foreach (exp_q[i]) begin
      if (exp_q[i] == EV_S) ns++;
      else if (exp_q[i] == EV_P) np++;
      else nb++;
    end
    ticks = 4 * ns + 4 * np + 36 * nb + 4 * (ns - 1);
    slv_silent = silent;
    slv_data   = sd;
    base       = mon_q.size();
    cmd_rd     = rd;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc_wait = n;
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge clk);
    chk("busy_accept", busy, 1);
    chk("ready_accept", cmd_ready, 0);
    if (!keep)
      cmd_valid = 1'b0;
    j = 0;
    bad = 0;
    while (!rsp_valid && j < 2000) begin
      @(negedge clk);
      j++;
      if (cmd_ready || !busy)
        bad++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      return;
    end
    chk("latency", j + 1, ticks * CLK_DIV + 1);
    chk("ready_busy_hold", bad, 0);
    chk("busy_rsp", busy, 1);
    chk("nack", rsp_nack, nk);
    if (rd && !nk)
      ref_rdata = rxb;
    chk("rdata", rsp_rdata, ref_rdata);
    chk("ev_count", mon_q.size() - base, exp_q.size());
    foreach (exp_q[i])
      if (base + i < mon_q.size())
        chk("bus_event", mon_q[base + i], exp_q[i]);
    if (!keep) begin
      @(negedge clk);
      chk("rsp_pulse", rsp_valid, 0);
      chk("ready_idle", cmd_ready, 1);
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, nv;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scl", scl_oe, 0);
    chk("rst_sda", sda_oe, 0);
    chk("rst_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_nack", rsp_nack, 0);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    xact(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, w);
    xact(1'b1, 8'h0A, 8'h00, 1'b0, 8'h26, 1'b0, w);
    xact(1'b0, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, w);
    xact(1'b0, 8'h55, 8'hAA, 1'b0, 8'h00, 1'b1, w);
    xact(1'b0, 8'h3C, 8'hC3, 1'b0, 8'h00, 1'b0, w);
    chk("b2b_accept_wait", w, 1);

    // One-cycle reset in the middle of the data byte
    cmd_rd    = 1'b0;
    cmd_addr  = 8'h11;
    cmd_wdata = 8'h5A;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (320) @(negedge clk);
    chk("busy_mid", busy, 1);
    reset_n = 1'b0;
    mon_en  = 1'b0;
    @(negedge clk);
    chk("mid_rst_scl", scl_oe, 0);
    chk("mid_rst_sda", sda_oe, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    reset_n = 1'b1;
    ref_rdata = 8'h00;
    @(negedge clk);
    chk("mid_rst_ready", cmd_ready, 1);
    nv = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) nv++;
    end
    chk("mid_rst_no_rsp", nv, 0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    xact(1'b1, 8'h1C, 8'h00, 1'b0, 8'hA5, 1'b0, w);

    for (int k = 0; k < 8; k++) begin
      xact(1'($urandom % 2), 8'($urandom), 8'($urandom),
           ($urandom % 4) == 0, 8'($urandom), 1'b0, w);
    end

    chk("scl_high_min", hi_min >= 2 * CLK_DIV, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
